// File: rtl/tnn_fe_pkg.sv
// Shared types and defaults for the TNN feature front end.
// Holds the frame FSM state encoding, threshold defaults and slot packing helper.
package tnn_fe_pkg;

   localparam int unsigned DEF_RAW_W  = 8;
   localparam int unsigned DEF_N_FEAT = 7;
   localparam int unsigned DEF_Q_W    = 2;
   localparam int unsigned DEF_T1     = 64;
   localparam int unsigned DEF_T2     = 128;
   localparam int unsigned DEF_T3     = 192;

   typedef enum logic [2:0] {
      ST_COLLECT = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_EVAL    = 3'd2,
      ST_ERR     = 3'd3,
      ST_HOLD    = 3'd4
   } fe_state_t;

   // Bit offset of feature slot k inside the packed classifier vector.
   function automatic int unsigned slot_off(input int unsigned k, input int unsigned qw);
      return k * qw;
   endfunction

endpackage

// File: rtl/tnn_feature_frontend_quant.sv
// Combinational 4-level quantizer: maps a raw sample onto a code using three thresholds.
// A sample equal to a threshold takes the higher code.
module feature_quantizer
   import tnn_fe_pkg::*;
#(
   parameter int unsigned      RAW_W = DEF_RAW_W,
   parameter int unsigned      Q_W   = DEF_Q_W,
   parameter logic [RAW_W-1:0] T1    = RAW_W'(DEF_T1),
   parameter logic [RAW_W-1:0] T2    = RAW_W'(DEF_T2),
   parameter logic [RAW_W-1:0] T3    = RAW_W'(DEF_T3)
) (
   input  logic [RAW_W-1:0] raw_i,
   output logic [Q_W-1:0]   code_o
);

   always_comb begin
      code_o = Q_W'(0);
      if (raw_i >= T3) begin
         code_o = Q_W'(3);
      end else if (raw_i >= T2) begin
         code_o = Q_W'(2);
      end else if (raw_i >= T1) begin
         code_o = Q_W'(1);
      end
   end

endmodule

// File: rtl/tnn_feature_frontend.sv
// Frame collector for the 2-bit TNN classifier: quantizes a stream of raw features,
// packs one frame into vec_o, samples the classifier bit and returns one result per frame.
module tnn_feature_frontend
   import tnn_fe_pkg::*;
#(
   parameter int unsigned      RAW_W  = DEF_RAW_W,
   parameter int unsigned      N_FEAT = DEF_N_FEAT,
   parameter int unsigned      Q_W    = DEF_Q_W,
   parameter logic [RAW_W-1:0] T1     = RAW_W'(DEF_T1),
   parameter logic [RAW_W-1:0] T2     = RAW_W'(DEF_T2),
   parameter logic [RAW_W-1:0] T3     = RAW_W'(DEF_T3)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [RAW_W-1:0]        in_data,
   input  logic                    in_last,
   output logic [N_FEAT*Q_W-1:0]   vec_o,
   output logic                    vec_valid,
   input  logic                    cls_i,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    res_class,
   output logic                    res_err
);

   localparam int unsigned          IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_FEAT - 1);

   fe_state_t        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             res_class_q, res_class_d;
   logic             res_err_q, res_err_d;

   logic [Q_W-1:0]   code;
   logic             accept;
   logic             collect_wr;
   logic             frame_clear;

   feature_quantizer #(
      .RAW_W (RAW_W),
      .Q_W   (Q_W),
      .T1    (T1),
      .T2    (T2),
      .T3    (T3)
   ) u_quant (
      .raw_i  (in_data),
      .code_o (code)
   );

   assign accept      = in_valid && in_ready;
   assign collect_wr  = accept && (state_q == ST_COLLECT);
   assign frame_clear = (state_q == ST_HOLD) && res_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               if (in_last) begin
                  state_d = (idx_q == IDX_LAST) ? ST_EVAL : ST_ERR;
               end else if (idx_q == IDX_LAST) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (accept && in_last) begin
               state_d = ST_ERR;
            end
         end
         ST_EVAL:  state_d = ST_HOLD;
         ST_ERR:   state_d = ST_HOLD;
         ST_HOLD: begin
            if (res_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default:  state_d = ST_COLLECT;
      endcase
   end

   // Output decode; in_ready is gated by rst so nothing is accepted during reset.
   always_comb begin
      in_ready  = 1'b0;
      vec_valid = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         ST_COLLECT: in_ready = !rst;
         ST_DRAIN:   in_ready = !rst;
         ST_EVAL:    vec_valid = 1'b1;
         ST_HOLD: begin
            res_valid = 1'b1;
            vec_valid = !res_err_q;
         end
         default: ;
      endcase
   end

   // Index and result datapath
   always_comb begin
      idx_d       = idx_q;
      res_class_d = res_class_q;
      res_err_d   = res_err_q;
      if (frame_clear) begin
         idx_d = '0;
      end else if (collect_wr && (idx_q != IDX_LAST)) begin
         idx_d = idx_q + IDX_W'(1);
      end
      if (state_q == ST_EVAL) begin
         res_class_d = cls_i;
         res_err_d   = 1'b0;
      end else if (state_q == ST_ERR) begin
         res_class_d = 1'b0;
         res_err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q       <= '0;
         res_class_q <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         res_class_q <= res_class_d;
         res_err_q   <= res_err_d;
      end
   end

   assign res_class = res_class_q;
   assign res_err   = res_err_q;

   generate
      for (genvar gi = 0; gi < N_FEAT; gi++) begin : gen_slot
         localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(gi);
         localparam int unsigned      OFF      = slot_off(gi, Q_W);

         logic [Q_W-1:0] slot_q, slot_d;

         always_comb begin
            slot_d = slot_q;
            if (frame_clear) begin
               slot_d = '0;
            end else if (collect_wr && (idx_q == SLOT_IDX)) begin
               slot_d = code;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q <= '0;
            end else begin
               slot_q <= slot_d;
            end
         end

         assign vec_o[OFF +: Q_W] = slot_q;
      end
   endgenerate

endmodule

// File: tb/tb_tnn_feature_frontend.sv
// Directed bench for tnn_feature_frontend: good, threshold-edge, short, long and reset-interrupted frames.
module tb_tnn_feature_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic [13:0] vec_o;
   logic        vec_valid;
   logic        cls_i;
   logic        res_valid;
   logic        res_ready;
   logic        res_class;
   logic        res_err;

   int checks   = 0;
   int failures = 0;

   tnn_feature_frontend dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .vec_o     (vec_o),
      .vec_valid (vec_valid),
      .cls_i     (cls_i),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_class (res_class),
      .res_err   (res_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one feature and returns 1ns after the accepting edge.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("send_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Completes the HOLD handshake and checks return to an empty COLLECT.
   task automatic take_result(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, "_post_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_post_vec_o"},     32'(vec_o),     32'h0);
      chk({tag, "_post_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      in_last   = 1'b0;
      cls_i     = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_vec_o",     32'(vec_o),     32'h0);
      chk("rst_vec_valid", 32'(vec_valid), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_class", 32'(res_class), 32'd0);
      chk("rst_res_err",   32'(res_err),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      $display("step reset: done");

      // Good frame, cls_i=1: codes 0,1,2,3,0,3,2
      cls_i = 1'b1;
      send(8'd10, 0); send(8'd70, 0); send(8'd130, 0); send(8'd200, 0);
      send(8'd0, 0);  send(8'd255, 0);
      send(8'd128, 1);
      chk("f1_eval_vec_valid", 32'(vec_valid), 32'd1);
      chk("f1_eval_res_valid", 32'(res_valid), 32'd0);
      chk("f1_eval_in_ready",  32'(in_ready),  32'd0);
      chk("f1_eval_vec_o",     32'(vec_o),     32'h2CE4);
      tick();
      chk("f1_hold_res_valid", 32'(res_valid), 32'd1);
      chk("f1_hold_res_class", 32'(res_class), 32'd1);
      chk("f1_hold_res_err",   32'(res_err),   32'd0);
      chk("f1_hold_vec_valid", 32'(vec_valid), 32'd1);
      take_result("f1");
      $display("step good_frame: vec=2CE4 class=1");

      // Threshold edges with cls_i=0, consumer stalls 5 cycles in HOLD
      cls_i = 1'b0;
      send(8'd63, 0); send(8'd64, 0); send(8'd127, 0); send(8'd128, 0);
      send(8'd191, 0); send(8'd192, 0);
      send(8'd255, 1);
      chk("f2_eval_vec_o", 32'(vec_o), 32'h3E94);
      cls_i = 1'b1;
      tick();
      cls_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("f2_stall_res_valid", 32'(res_valid), 32'd1);
         chk("f2_stall_res_class", 32'(res_class), 32'd1);
         chk("f2_stall_vec_o",     32'(vec_o),     32'h3E94);
         chk("f2_stall_in_ready",  32'(in_ready),  32'd0);
         tick();
      end
      take_result("f2");
      $display("step threshold_edges_stall: vec=3E94 class=1");

      // Short frame: in_last on 3rd feature, codes 0,1,2
      cls_i = 1'b1;
      send(8'd10, 0); send(8'd70, 0);
      send(8'd130, 1);
      chk("sh_err_vec_valid", 32'(vec_valid), 32'd0);
      chk("sh_err_res_valid", 32'(res_valid), 32'd0);
      tick();
      chk("sh_hold_res_valid", 32'(res_valid), 32'd1);
      chk("sh_hold_res_err",   32'(res_err),   32'd1);
      chk("sh_hold_res_class", 32'(res_class), 32'd0);
      chk("sh_hold_vec_valid", 32'(vec_valid), 32'd0);
      chk("sh_hold_vec_o",     32'(vec_o),     32'h24);
      take_result("sh");
      send(8'd63, 0); send(8'd64, 0); send(8'd127, 0); send(8'd128, 0);
      send(8'd191, 0); send(8'd192, 0);
      send(8'd255, 1);
      chk("sh_next_vec_o", 32'(vec_o), 32'h3E94);
      tick();
      chk("sh_next_res_class", 32'(res_class), 32'd1);
      chk("sh_next_res_err",   32'(res_err),   32'd0);
      take_result("sh_next");
      $display("step short_frame: err=1 then good frame class=1");

      // Long frame: 9 features, last two drained
      send(8'd10, 0); send(8'd70, 0); send(8'd130, 0); send(8'd200, 0);
      send(8'd0, 0);  send(8'd255, 0); send(8'd128, 0);
      chk("lg_drain_in_ready",  32'(in_ready),  32'd1);
      chk("lg_drain_vec_valid", 32'(vec_valid), 32'd0);
      send(8'd250, 0);
      chk("lg_drain2_res_valid", 32'(res_valid), 32'd0);
      send(8'd5, 1);
      tick();
      chk("lg_hold_res_valid", 32'(res_valid), 32'd1);
      chk("lg_hold_res_err",   32'(res_err),   32'd1);
      chk("lg_hold_res_class", 32'(res_class), 32'd0);
      chk("lg_hold_vec_valid", 32'(vec_valid), 32'd0);
      chk("lg_hold_vec_o",     32'(vec_o),     32'h2CE4);
      take_result("lg");
      repeat (3) tick();
      chk("lg_no_second_res", 32'(res_valid), 32'd0);
      $display("step long_frame: one error result");

      // Reset after 4 features, then a full frame with cls_i=0
      send(8'd200, 0); send(8'd200, 0); send(8'd200, 0); send(8'd200, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_vec_o",    32'(vec_o),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_res_valid", 32'(res_valid), 32'd0);
      cls_i = 1'b0;
      send(8'd10, 0); send(8'd70, 0); send(8'd130, 0); send(8'd200, 0);
      send(8'd0, 0);  send(8'd255, 0);
      send(8'd128, 1);
      chk("rs_eval_vec_o",     32'(vec_o),     32'h2CE4);
      chk("rs_eval_res_valid", 32'(res_valid), 32'd0);
      tick();
      chk("rs_hold_res_valid", 32'(res_valid), 32'd1);
      chk("rs_hold_res_class", 32'(res_class), 32'd0);
      chk("rs_hold_res_err",   32'(res_err),   32'd0);
      take_result("rs");
      $display("step reset_mid_frame: class=0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
